// File: rtl/register_read_port.sv
// Two-port register-bank read port with write bypass, a one-deep output snapshot,
// and a sequential R0..R15 dump mode on port A.
module register_read_port (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] q0,
  input  logic [31:0] q1,
  input  logic [31:0] q2,
  input  logic [31:0] q3,
  input  logic [31:0] q4,
  input  logic [31:0] q5,
  input  logic [31:0] q6,
  input  logic [31:0] q7,
  input  logic [31:0] q8,
  input  logic [31:0] q9,
  input  logic [31:0] q10,
  input  logic [31:0] q11,
  input  logic [31:0] q12,
  input  logic [31:0] q13,
  input  logic [31:0] q14,
  input  logic [31:0] q15,
  input  logic [15:0] wr_en,
  input  logic [31:0] wr_data,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        scan_start,
  output logic [31:0] douta,
  output logic [31:0] doutb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        scan_active,
  output logic [3:0]  scan_idx
);

  typedef enum logic [1:0] {StIdle, StHold, StScan} state_e;

  state_e      state_q, state_d;
  logic [31:0] douta_q, douta_d;
  logic [31:0] doutb_q, doutb_d;
  logic        out_valid_q, out_valid_d;
  logic [3:0]  scan_idx_q, scan_idx_d;
  logic [3:0]  scan_next;

  logic [31:0] bank [16];
  logic [31:0] sel  [16];

  always_comb begin
    bank[0]  = q0;
    bank[1]  = q1;
    bank[2]  = q2;
    bank[3]  = q3;
    bank[4]  = q4;
    bank[5]  = q5;
    bank[6]  = q6;
    bank[7]  = q7;
    bank[8]  = q8;
    bank[9]  = q9;
    bank[10] = q10;
    bank[11] = q11;
    bank[12] = q12;
    bank[13] = q13;
    bank[14] = q14;
    bank[15] = q15;
  end

  // Same-cycle write bypass; each enable bit is independent, so several may hit at once.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sel[i] = wr_en[i] ? wr_data : bank[i];
    end
  end

  assign scan_next = scan_idx_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    douta_d     = douta_q;
    doutb_d     = doutb_q;
    out_valid_d = out_valid_q;
    scan_idx_d  = scan_idx_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          douta_d     = sel[ra];
          doutb_d     = sel[rb];
          out_valid_d = 1'b1;
          state_d     = StHold;
        end else if (scan_start) begin
          douta_d     = sel[0];
          doutb_d     = 32'd0;
          scan_idx_d  = 4'd0;
          out_valid_d = 1'b1;
          state_d     = StScan;
        end
      end
      StHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      StScan: begin
        if (out_ready) begin
          if (scan_idx_q == 4'd15) begin
            out_valid_d = 1'b0;
            scan_idx_d  = 4'd0;
            state_d     = StIdle;
          end else begin
            scan_idx_d = scan_next;
            douta_d    = sel[scan_next];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      douta_q     <= 32'd0;
      doutb_q     <= 32'd0;
      out_valid_q <= 1'b0;
      scan_idx_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      douta_q     <= douta_d;
      doutb_q     <= doutb_d;
      out_valid_q <= out_valid_d;
      scan_idx_q  <= scan_idx_d;
    end
  end

  assign req_ready   = (state_q == StIdle) && !reset;
  assign douta       = douta_q;
  assign doutb       = doutb_q;
  assign out_valid   = out_valid_q;
  assign scan_active = (state_q == StScan);
  assign scan_idx    = scan_idx_q;

endmodule
